// File: rtl/gray_ptr_receiver.sv
// Far-side gray pointer receiver for an async FIFO: syncs the remote gray pointer,
// decodes both pointers and registers occupancy, empty/full and almost flags.
// Optional sticky gray-step checker built when GRAY_CHECK_EN is defined.
module gray_ptr_receiver #(
  parameter int unsigned ADDR_W    = 4,
  parameter bit          READ_SIDE = 1'b1,
  parameter int unsigned ALMOST_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   local_gray_i,
  input  logic [ADDR_W:0]   remote_gray_i,
  output logic [ADDR_W:0]   remote_bin_o,
  output logic [ADDR_W:0]   level_o,
  output logic              flag_o,
  output logic              almost_o,
  output logic              gray_err_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AEMPTY_P  = PTR_W'(ALMOST_TH);
  localparam logic [PTR_W-1:0] AFULL_P   = PTR_W'(DEPTH - ALMOST_TH);
  localparam logic             FLAG_RST   = READ_SIDE;
  localparam logic             ALMOST_RST = READ_SIDE ? 1'b1 : (ALMOST_TH == DEPTH);

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_W-1:0] sync1_q, sync2_q;
  logic [PTR_W-1:0] remote_bin_q, remote_bin_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] local_bin_c;
  logic             flag_q, flag_d;
  logic             almost_q, almost_d;

  // Occupancy is plain modular subtraction; wrap needs no special handling.
  always_comb begin
    remote_bin_d = gray2bin(sync2_q);
    local_bin_c  = gray2bin(local_gray_i);
    level_d      = READ_SIDE ? (remote_bin_d - local_bin_c) : (local_bin_c - remote_bin_d);
    flag_d       = READ_SIDE ? (level_d == '0) : (level_d == DEPTH_P);
    almost_d     = READ_SIDE ? (level_d <= AEMPTY_P) : (level_d >= AFULL_P);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      remote_bin_q <= '0;
      level_q      <= '0;
      flag_q       <= FLAG_RST;
      almost_q     <= ALMOST_RST;
    end else begin
      sync1_q      <= remote_gray_i;
      sync2_q      <= sync1_q;
      remote_bin_q <= remote_bin_d;
      level_q      <= level_d;
      flag_q       <= flag_d;
      almost_q     <= almost_d;
    end
  end

  assign remote_bin_o = remote_bin_q;
  assign level_o      = level_q;
  assign flag_o       = flag_q;
  assign almost_o     = almost_q;

`ifdef GRAY_CHECK_EN
  logic [PTR_W-1:0] prev_q;
  logic [PTR_W-1:0] step_c;
  logic             gray_err_q, gray_err_d;

  // More than one bit changing between synchronized samples is an illegal gray step.
  always_comb begin
    step_c     = sync2_q ^ prev_q;
    gray_err_d = gray_err_q | ((step_c & (step_c - PTR_W'(1))) != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q     <= '0;
      gray_err_q <= 1'b0;
    end else begin
      prev_q     <= sync2_q;
      gray_err_q <= gray_err_d;
    end
  end

  assign gray_err_o = gray_err_q;
`else
  assign gray_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Bench for gray_ptr_receiver: one read-side and one write-side instance on a shared
// FIFO pointer pair, directed cases plus random push/pop against a history model.
module tb_gray_ptr_receiver;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TH    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] wptr_g = '0;
  logic [4:0] rptr_g = '0;

  logic [4:0] rd_bin, rd_lvl, wr_bin, wr_lvl;
  logic       rd_flag, rd_alm, rd_err, wr_flag, wr_alm, wr_err;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  gray_ptr_receiver #(.ADDR_W(4), .READ_SIDE(1'b1), .ALMOST_TH(TH)) u_rd (
    .clk(clk), .rst(rst),
    .local_gray_i(rptr_g), .remote_gray_i(wptr_g),
    .remote_bin_o(rd_bin), .level_o(rd_lvl), .flag_o(rd_flag),
    .almost_o(rd_alm), .gray_err_o(rd_err)
  );

  gray_ptr_receiver #(.ADDR_W(4), .READ_SIDE(1'b0), .ALMOST_TH(TH)) u_wr (
    .clk(clk), .rst(rst),
    .local_gray_i(wptr_g), .remote_gray_i(rptr_g),
    .remote_bin_o(wr_bin), .level_o(wr_lvl), .flag_o(wr_flag),
    .almost_o(wr_alm), .gray_err_o(wr_err)
  );

  // Binary bit i of a gray code is the parity of all gray bits at or above i.
  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    logic [4:0] t;
    for (int i = 0; i < 5; i++) begin
      t    = g >> i;
      b[i] = ^t;
    end
    return b;
  endfunction

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  bit gc_en;
  initial begin
`ifdef GRAY_CHECK_EN
    gc_en = 1'b1;
`else
    gc_en = 1'b0;
`endif
  end

  // Model: per-edge history of driven pointers; the remote pointer is seen two edges late
  logic [4:0] wh [4];
  logic [4:0] rh [4];
  logic [4:0] e_rd_bin, e_rd_lvl, e_wr_bin, e_wr_lvl;
  logic       e_rd_flag, e_rd_alm, e_rd_err, e_wr_flag, e_wr_alm, e_wr_err;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        wh[i] = '0;
        rh[i] = '0;
      end
      e_rd_bin = '0; e_rd_lvl = '0; e_rd_flag = 1'b1; e_rd_alm = 1'b1; e_rd_err = 1'b0;
      e_wr_bin = '0; e_wr_lvl = '0; e_wr_flag = 1'b0; e_wr_alm = (TH == DEPTH); e_wr_err = 1'b0;
    end else begin
      for (int i = 3; i > 0; i--) begin
        wh[i] = wh[i-1];
        rh[i] = rh[i-1];
      end
      wh[0] = wptr_g;
      rh[0] = rptr_g;
      e_rd_bin  = g2b(wh[2]);
      e_rd_lvl  = e_rd_bin - g2b(rh[0]);
      e_rd_flag = (int'(e_rd_lvl) == 0);
      e_rd_alm  = (int'(e_rd_lvl) <= int'(TH));
      e_wr_bin  = g2b(rh[2]);
      e_wr_lvl  = g2b(wh[0]) - e_wr_bin;
      e_wr_flag = (int'(e_wr_lvl) == int'(DEPTH));
      e_wr_alm  = (int'(e_wr_lvl) >= int'(DEPTH - TH));
      if (gc_en && $countones(wh[2] ^ wh[3]) > 1) e_rd_err = 1'b1;
      if (gc_en && $countones(rh[2] ^ rh[3]) > 1) e_wr_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd.remote_bin", 32'(rd_bin), 32'(e_rd_bin));
      chk("rd.level", 32'(rd_lvl), 32'(e_rd_lvl));
      chk("rd.flag", 32'(rd_flag), 32'(e_rd_flag));
      chk("rd.almost", 32'(rd_alm), 32'(e_rd_alm));
      chk("rd.gray_err", 32'(rd_err), 32'(e_rd_err));
      chk("wr.remote_bin", 32'(wr_bin), 32'(e_wr_bin));
      chk("wr.level", 32'(wr_lvl), 32'(e_wr_lvl));
      chk("wr.flag", 32'(wr_flag), 32'(e_wr_flag));
      chk("wr.almost", 32'(wr_alm), 32'(e_wr_alm));
      chk("wr.gray_err", 32'(wr_err), 32'(e_wr_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] w, r, occ;
  int bias;

  initial begin
    // Reset state
    tick(); tick();
    chk_on = 1'b1;
    chk("t1.rd_level", 32'(rd_lvl), 0);
    chk("t1.rd_flag", 32'(rd_flag), 1);
    chk("t1.rd_almost", 32'(rd_alm), 1);
    chk("t1.rd_err", 32'(rd_err), 0);
    chk("t1.wr_flag", 32'(wr_flag), 0);
    chk("t1.wr_almost", 32'(wr_alm), 0);
    rst = 1'b1;
    tick();

    // Read side sees remote writes three edges late
    wptr_g = 5'h01; tick();
    chk("t2.rd_level_e1", 32'(rd_lvl), 0);
    wptr_g = 5'h03; tick();
    chk("t2.rd_level_e2", 32'(rd_lvl), 0);
    chk("t2.wr_level_e2", 32'(wr_lvl), 2);
    tick();
    chk("t2.rd_level_e3", 32'(rd_lvl), 1);
    chk("t2.rd_flag_e3", 32'(rd_flag), 0);
    chk("t2.rd_almost_e3", 32'(rd_alm), 1);
    tick();
    chk("t2.rd_level_e4", 32'(rd_lvl), 2);
    chk("t2.rd_almost_e4", 32'(rd_alm), 1);

    // Write side: full after one edge, release three edges after a remote read
    wptr_g = 5'h18; tick();
    chk("t3.wr_level", 32'(wr_lvl), 16);
    chk("t3.wr_flag", 32'(wr_flag), 1);
    chk("t3.wr_almost", 32'(wr_alm), 1);
    rptr_g = 5'h01; tick(); tick();
    chk("t3.wr_level_hold", 32'(wr_lvl), 16);
    tick();
    chk("t3.wr_level_rel", 32'(wr_lvl), 15);
    chk("t3.wr_flag_rel", 32'(wr_flag), 0);

    // Pointer wrap
    rptr_g = 5'h1E; wptr_g = 5'h10; tick(); tick(); tick();
    chk("t4.wr_level_a", 32'(wr_lvl), 11);
    wptr_g = 5'h00; tick();
    chk("t4.wr_level_b", 32'(wr_lvl), 12);
    chk("t4.wr_flag", 32'(wr_flag), 0);

    // Illegal two-bit gray step
    rst = 1'b0; rptr_g = '0; wptr_g = '0; tick();
    chk("t5.rd_err_rst", 32'(rd_err), 0);
    rst = 1'b1; tick();
    wptr_g = 5'h03; tick();
    chk("t5.rd_err_e1", 32'(rd_err), 0);
    tick();
    chk("t5.rd_err_e2", 32'(rd_err), 0);
    tick();
    chk("t5.rd_err_e3", 32'(rd_err), 32'(gc_en));
    tick(); tick();
    chk("t5.rd_err_hold", 32'(rd_err), 32'(gc_en));

    // Mid-operation reset
    rst = 1'b0; wptr_g = '0; tick();
    rst = 1'b1; wptr_g = 5'h04; tick(); tick(); tick();
    chk("t6.rd_level_pre", 32'(rd_lvl), 7);
    rst = 1'b0; tick();
    chk("t6.rd_level", 32'(rd_lvl), 0);
    chk("t6.rd_bin", 32'(rd_bin), 0);
    chk("t6.rd_flag", 32'(rd_flag), 1);
    chk("t6.rd_err", 32'(rd_err), 0);
    rst = 1'b1;

    // Random legal push/pop traffic with occasional resets
    w = 5'd7; r = 5'd0; bias = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) bias = int'($urandom_range(10, 90));
      occ = w - r;
      if (($urandom % 100) < 32'(bias) && int'(occ) < int'(DEPTH)) w = w + 5'd1;
      if (($urandom % 100) >= 32'(bias) && int'(occ) > 0) r = r + 5'd1;
      wptr_g = b2g(w);
      rptr_g = b2g(r);
      rst = (($urandom % 400) != 0);
      tick();
    end
    rst = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
